stim_sig_harness: RTL and testbench
===================================

Name: stim_sig_harness

Overview:
- Stimulus/response stage wrapped around the 96-bit fuzz DUT (in_data -> out_data).
- Upstream half: LFSR-driven generator producing a registered 96-bit vector per cycle into the DUT's in_data.
- Downstream half: MISR compacting the DUT's out_data into a 32-bit signature.
- A start/done FSM controls a run of N vectors so that two simulators' signatures can be compared.

Parameters:
- DATA_W, 96, vector width; must equal the DUT in_data/out_data width and be a multiple of 32.
- SIG_W, 32, LFSR/MISR width; fixed at 32 by the polynomial.
- CNT_W, 16, vector counter width.
- LAT, 0, DUT response latency in cycles (0 = combinational DUT).

Ports:
- clkin_data  in  1  sole clock, rising edge.
- rstin_data  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle run request; sampled in IDLE/DONE only.
- seed  in  32  LFSR seed; captured on accepted start.
- num_vectors  in  CNT_W  vectors per run; captured on accepted start.
- dut_in_data  out  DATA_W  registered stimulus; drives DUT in_data.
- dut_out_data  in  DATA_W  DUT response (DUT out_data).
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE until the next accepted start.
- signature  out  SIG_W  MISR state.
- vec_count  out  CNT_W  vectors applied so far in this run.

Behaviour:
- Reset values: all outputs 0; FSM=IDLE; lfsr=32'h1; MISR=0.
- Reset is async assert. Mid-run reset aborts the run immediately with no partial done.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE + start: capture seed (seed==0 is replaced by 32'h1 to avoid lockup) and num_vectors; clear MISR, vec_count and done.
  - Accepted start goes to RUN, or to DRAIN if num_vectors==0.
  - RUN: one vector per cycle. Advance lfsr, register dut_in_data, increment vec_count.
  - RUN -> DRAIN on the cycle vec_count reaches num_vectors.
  - DRAIN: wait LAT cycles (0 cycles when LAT=0; DRAIN then lasts exactly 1 cycle for the final capture), then go to DONE.
  - DONE: done=1; signature and last dut_in_data hold.
- start is ignored while busy. start is accepted again in DONE (restart).
- LFSR:
  - 32-bit Galois, polynomial x^32+x^22+x^2+x+1 (taps mask 32'h80200003), shifts right.
  - Step rule: next = (s>>1) ^ (s[0] ? 32'h80200003 : 0).
- Vector for LFSR state s: {s, ~s, s ^ {s[15:0],s[31:16]}}.
  - The first vector of a run uses the captured seed itself; the LFSR steps after each use.
  - For DATA_W > 96, this 96-bit pattern is replicated from the LSB.
- MISR:
  - Each response cycle: sig <= step(sig) ^ fold(dut_out_data), where step is the same Galois step and fold = XOR of all 32-bit slices.
  - A response is sampled exactly LAT+1 edges after its vector's registering edge.
  - Exactly num_vectors responses are compacted; no captures occur outside RUN/DRAIN.
- vec_count saturates at num_vectors and does not wrap. num_vectors = 2^CNT_W-1 is legal.

Optional Feature:
- Macro: STIM_HOLD_EN.
- When defined, adds input port hold (1 bit). While hold=1 in RUN:
  - lfsr, dut_in_data, vec_count and the FSM freeze.
  - No MISR update for the held cycle.
  - The pipelined responses for LAT>0 are delayed by the same amount.
- hold is ignored outside RUN.
- When not defined: no port and no freeze logic. Behaviour equals STIM_HOLD_EN with hold tied 0.

Decomposition:
- Package stim_sig_pkg:
  - LFSR_POLY = 32'h80200003.
  - Function lfsr_step(logic [31:0]).
  - Function fold96 (slice XOR).
  - Enum fsm_e {IDLE, RUN, DRAIN, DONE}.
- One sub-module, sig_misr: registers, clear, enable, data_in; used for the compaction. Generator and FSM stay in the top.

Test Plan:
- Reset, then seed=1, num_vectors=1, loopback (dut_out_data=dut_in_data):
  - first dut_in_data = {32'h00000001, 32'hFFFFFFFE, 32'h00010001};
  - done after 2 cycles; signature = 32'h00010001 ^ 32'hFFFFFFFE ^ 32'h00000001 = 32'hFFFEFFFE.
- seed=0, num_vectors=1 -> identical results to seed=1.
- num_vectors=0 -> DRAIN 1 cycle then DONE; signature=0; vec_count=0; no dut_in_data change.
- seed=32'hACE1, num_vectors=1000, loopback:
  - signature matches the package-function reference model;
  - a start pulse at vector 500 is ignored;
  - rerun with the same seed reproduces the identical signature.
- rstin_data pulsed asynchronously (between edges) at vector 10:
  - all outputs 0 immediately; FSM=IDLE; a new start runs cleanly.
- STIM_HOLD_EN, hold high 5 cycles mid-run:
  - vector stream frozen;
  - final signature equals the no-hold run; done arrives 5 cycles later.

Source files
------------

// File: rtl/stim_sig_pkg.sv
// Shared definitions for the stimulus/signature harness: the LFSR polynomial,
// the Galois step used by both generator and MISR, the 96-bit slice fold and the FSM states.
package stim_sig_pkg;

    localparam logic [31:0] LFSR_POLY = 32'h80200003;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } fsm_e;

    // Right-shifting Galois step for x^32+x^22+x^2+x+1
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

    function automatic logic [31:0] fold96(input logic [95:0] v);
        return v[95:64] ^ v[63:32] ^ v[31:0];
    endfunction

endpackage

// File: rtl/sig_misr.sv
// Multiple-input signature register: clears on request, otherwise folds data_i
// into a Galois-stepped 32-bit state on every enabled cycle.
module sig_misr
    import stim_sig_pkg::*;
#(
    parameter int SIG_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [SIG_W-1:0] data_i,
    output logic [SIG_W-1:0] sig_o
);

    logic [SIG_W-1:0] sig_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sig_q <= '0;
        end else if (clear_i) begin
            sig_q <= '0;
        end else if (enable_i) begin
            sig_q <= lfsr_step(sig_q) ^ data_i;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/stim_sig_harness.sv
// LFSR stimulus generator, response MISR and run-control FSM around a fuzz DUT.
// Optional macro STIM_HOLD_EN adds a 'hold' input that freezes a run in progress.
module stim_sig_harness
    import stim_sig_pkg::*;
#(
    parameter int DATA_W = 96,
    parameter int SIG_W  = 32,
    parameter int CNT_W  = 16,
    parameter int LAT    = 0
) (
    input  logic              clkin_data,
    input  logic              rstin_data,
    input  logic              start,
    input  logic [31:0]       seed,
    input  logic [CNT_W-1:0]  num_vectors,
`ifdef STIM_HOLD_EN
    input  logic              hold,
`endif
    input  logic [DATA_W-1:0] dut_out_data,
    output logic [DATA_W-1:0] dut_in_data,
    output logic              busy,
    output logic              done,
    output logic [SIG_W-1:0]  signature,
    output logic [CNT_W-1:0]  vec_count
);

    localparam int PW  = 96;
    localparam int DRW = $clog2(LAT + 1) + 1;
    localparam logic [DRW-1:0] LAT_C = DRW'(LAT);

    fsm_e              state_q;
    logic [31:0]       lfsr_q;
    logic [DATA_W-1:0] din_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  num_q;
    logic [DRW-1:0]    drain_q;
    logic              busy_q;
    logic              done_q;
    logic [LAT:0]      vld_q;

    logic [PW-1:0]     pat;
    logic [DATA_W-1:0] vec_d;
    logic [SIG_W-1:0]  fold_d;
    logic [31:0]       seed_fix;
    logic [CNT_W-1:0]  cnt_inc;
    logic              hold_run;
    logic              run_adv;
    logic              accept;
    logic              capture;

`ifdef STIM_HOLD_EN
    assign hold_run = (state_q == RUN) && hold;
`else
    assign hold_run = 1'b0;
`endif

    assign seed_fix = (seed == 32'h0) ? 32'h1 : seed;
    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign accept   = start && ((state_q == IDLE) || (state_q == DONE));
    assign run_adv  = (state_q == RUN) && !hold_run;
    assign capture  = vld_q[LAT] && !hold_run;

    // Wider vectors repeat the 96-bit pattern upward from the LSB
    always_comb begin
        pat = {lfsr_q, ~lfsr_q, lfsr_q ^ {lfsr_q[15:0], lfsr_q[31:16]}};
        vec_d = '0;
        for (int i = 0; i < DATA_W; i++) begin
            vec_d[i] = pat[i % PW];
        end
    end

    always_comb begin
        fold_d = '0;
        for (int i = 0; i < DATA_W / 32; i++) begin
            fold_d = fold_d ^ dut_out_data[i*32 +: 32];
        end
    end

    always_ff @(posedge clkin_data or posedge rstin_data) begin
        if (rstin_data) begin
            state_q <= IDLE;
            lfsr_q  <= 32'h1;
            din_q   <= '0;
            cnt_q   <= '0;
            num_q   <= '0;
            drain_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        lfsr_q  <= seed_fix;
                        num_q   <= num_vectors;
                        cnt_q   <= '0;
                        drain_q <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        state_q <= (num_vectors == '0) ? DRAIN : RUN;
                    end
                end
                RUN: begin
                    if (!hold_run) begin
                        din_q  <= vec_d;
                        lfsr_q <= lfsr_step(lfsr_q);
                        cnt_q  <= cnt_inc;
                        if (cnt_inc == num_q) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_q == LAT_C) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= drain_q + DRW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tracks which edges carry a response due for compaction, LAT+1 edges after registering
    always_ff @(posedge clkin_data or posedge rstin_data) begin
        if (rstin_data) begin
            vld_q <= '0;
        end else if (!hold_run) begin
            vld_q[0] <= run_adv;
            for (int i = 1; i <= LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    sig_misr #(
        .SIG_W(SIG_W)
    ) u_misr (
        .clk_i   (clkin_data),
        .rst_i   (rstin_data),
        .clear_i (accept),
        .enable_i(capture),
        .data_i  (fold_d),
        .sig_o   (signature)
    );

    assign dut_in_data = din_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign vec_count   = cnt_q;

endmodule

// File: tb/tb_stim_sig_harness.sv
// Self-checking bench for stim_sig_harness: a loopback DUT with an optional XOR mask,
// a table of short directed runs, plus long-run, mid-run reset and (STIM_HOLD_EN) hold sequences.
module tb_stim_sig_harness;
    import stim_sig_pkg::*;

    localparam int DATA_W = 96;
    localparam int SIG_W  = 32;
    localparam int CNT_W  = 16;
    localparam int LIMIT  = 5000;

    typedef struct {
        logic [31:0]      seed;
        logic [CNT_W-1:0] num;
        logic [95:0]      mask;
        logic [31:0]      expSig;
        logic [95:0]      expVec;
        logic [CNT_W-1:0] expCount;
        int               expLat;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              hold = 1'b0;
    logic [31:0]       seed = 32'h0;
    logic [CNT_W-1:0]  numVec = '0;
    logic [DATA_W-1:0] outMask = '0;
    logic [DATA_W-1:0] dutIn;
    logic [DATA_W-1:0] dutOut;
    logic              busy;
    logic              done;
    logic [SIG_W-1:0]  sig;
    logic [CNT_W-1:0]  vecCount;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    vec_t table_q [5];

    assign dutOut = dutIn ^ outMask;

    always #5 clk = ~clk;

    stim_sig_harness #(
        .DATA_W(DATA_W),
        .SIG_W (SIG_W),
        .CNT_W (CNT_W),
        .LAT   (0)
    ) dut (
        .clkin_data  (clk),
        .rstin_data  (rst),
        .start       (start),
        .seed        (seed),
        .num_vectors (numVec),
`ifdef STIM_HOLD_EN
        .hold        (hold),
`endif
        .dut_out_data(dutOut),
        .dut_in_data (dutIn),
        .busy        (busy),
        .done        (done),
        .signature   (sig),
        .vec_count   (vecCount)
    );

    task automatic checkOutput(input string name, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    // Leaves the bench at the negedge following the accepting edge, with cyc = 0
    task automatic applyStimulus(input logic [31:0] s, input logic [CNT_W-1:0] n);
        @(negedge clk);
        seed   = s;
        numVec = n;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cyc    = 0;
    endtask

    task automatic waitDone();
        while (!done && cyc < LIMIT) tick();
        checkOutput("done reached", {95'b0, done}, 96'h1);
    endtask

    task automatic waitCount(input logic [CNT_W-1:0] target);
        while (vecCount != target && cyc < LIMIT) tick();
        checkOutput("count reached", {80'b0, vecCount}, {80'b0, target});
    endtask

    function automatic logic [95:0] vecOf(input logic [31:0] s);
        return {s, ~s, s ^ {s[15:0], s[31:16]}};
    endfunction

    task automatic runModel(input logic [31:0] s0, input int n, input logic [95:0] mask,
                            output logic [31:0] expSig, output logic [95:0] lastVec);
        logic [31:0] s;
        s       = (s0 == 32'h0) ? 32'h1 : s0;
        expSig  = 32'h0;
        lastVec = 96'h0;
        for (int i = 0; i < n; i++) begin
            lastVec = vecOf(s);
            expSig  = lfsr_step(expSig) ^ fold96(lastVec ^ mask);
            s       = lfsr_step(s);
        end
    endtask

    initial begin
        logic [31:0] mSig;
        logic [95:0] mVec;

        table_q[0] = '{32'h1, 16'd1, 96'h0, 32'hFFFEFFFE,
                       {32'h00000001, 32'hFFFFFFFE, 32'h00010001}, 16'd1, 2};
        table_q[1] = '{32'h0, 16'd1, 96'h0, 32'hFFFEFFFE,
                       {32'h00000001, 32'hFFFFFFFE, 32'h00010001}, 16'd1, 2};
        table_q[2] = '{32'h1, 16'd2, 96'h0, 32'h00230023,
                       {32'h80200003, 32'h7FDFFFFC, 32'h80238023}, 16'd2, 3};
        table_q[3] = '{32'h5, 16'd0, 96'h0, 32'h00000000,
                       {32'h80200003, 32'h7FDFFFFC, 32'h80238023}, 16'd0, 1};
        table_q[4] = '{32'h1, 16'd1, {96{1'b1}}, 32'h00010001,
                       {32'h00000001, 32'hFFFFFFFE, 32'h00010001}, 16'd1, 2};

        #2 rst = 1'b1;
        #6;
        checkOutput("reset dut_in_data", dutIn, 96'h0);
        checkOutput("reset busy", {95'b0, busy}, 96'h0);
        checkOutput("reset done", {95'b0, done}, 96'h0);
        checkOutput("reset signature", {64'b0, sig}, 96'h0);
        checkOutput("reset vec_count", {80'b0, vecCount}, 96'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            outMask = table_q[i].mask;
            applyStimulus(table_q[i].seed, table_q[i].num);
            checkOutput($sformatf("busy after start %0d", i), {95'b0, busy}, 96'h1);
            waitDone();
            checkOutput($sformatf("latency %0d", i), 96'(cyc), 96'(table_q[i].expLat));
            checkOutput($sformatf("signature %0d", i), {64'b0, sig}, {64'b0, table_q[i].expSig});
            checkOutput($sformatf("last vector %0d", i), dutIn, table_q[i].expVec);
            checkOutput($sformatf("vec_count %0d", i), {80'b0, vecCount}, {80'b0, table_q[i].expCount});
        end
        outMask = '0;

        runModel(32'hACE1, 1000, 96'h0, mSig, mVec);
        for (int r = 0; r < 2; r++) begin
            applyStimulus(32'hACE1, 16'd1000);
            waitCount(16'd500);
            seed   = 32'h1234;
            numVec = 16'd3;
            start  = 1'b1;
            tick();
            start  = 1'b0;
            checkOutput($sformatf("busy through ignored start %0d", r), {95'b0, busy}, 96'h1);
            waitDone();
            checkOutput($sformatf("long latency %0d", r), 96'(cyc), 96'(1001));
            checkOutput($sformatf("long signature %0d", r), {64'b0, sig}, {64'b0, mSig});
            checkOutput($sformatf("long last vector %0d", r), dutIn, mVec);
            checkOutput($sformatf("long vec_count %0d", r), {80'b0, vecCount}, 96'd1000);
            repeat (3) tick();
            checkOutput($sformatf("done holds %0d", r), {95'b0, done}, 96'h1);
            checkOutput($sformatf("signature holds %0d", r), {64'b0, sig}, {64'b0, mSig});
        end

        applyStimulus(32'h7, 16'd50);
        waitCount(16'd10);
        #2 rst = 1'b1;
        #1;
        checkOutput("abort dut_in_data", dutIn, 96'h0);
        checkOutput("abort busy", {95'b0, busy}, 96'h0);
        checkOutput("abort done", {95'b0, done}, 96'h0);
        checkOutput("abort signature", {64'b0, sig}, 96'h0);
        checkOutput("abort vec_count", {80'b0, vecCount}, 96'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("no partial done", {95'b0, done}, 96'h0);
        applyStimulus(32'h1, 16'd2);
        waitDone();
        checkOutput("post-reset latency", 96'(cyc), 96'd3);
        checkOutput("post-reset signature", {64'b0, sig}, 96'h00230023);

`ifdef STIM_HOLD_EN
        runModel(32'h1, 5, 96'h0, mSig, mVec);
        applyStimulus(32'h1, 16'd20);
        waitCount(16'd5);
        hold = 1'b1;
        for (int h = 0; h < 5; h++) begin
            tick();
            checkOutput($sformatf("held vector %0d", h), dutIn, mVec);
            checkOutput($sformatf("held count %0d", h), {80'b0, vecCount}, 96'd5);
        end
        hold = 1'b0;
        runModel(32'h1, 20, 96'h0, mSig, mVec);
        waitDone();
        checkOutput("hold latency", 96'(cyc), 96'd26);
        checkOutput("hold signature", {64'b0, sig}, {64'b0, mSig});
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
